// File: rtl/tl_pkg.sv
// ----------------------------------------------------------------------------
// tl_pkg
// Shared definitions for the transaction-layer VC ingress router.
//   state_e   one-hot link state published to the downstream pop arbiter
//   VC_W      width of the class (VC select) field
//   NUM_VC    number of virtual-channel FIFOs
// ----------------------------------------------------------------------------
package tl_pkg;

    localparam int VC_W   = 2;
    localparam int NUM_VC = 4;

    // One-hot encoding is part of the interface: the pop arbiter decodes
    // these bits directly, so the values must not be re-encoded.
    typedef enum logic [3:0] {
        ST_RESET  = 4'b0001,
        ST_INIT   = 4'b0010,
        ST_IDLE   = 4'b0100,
        ST_ACTIVE = 4'b1000
    } state_e;

endpackage : tl_pkg

// File: rtl/tl_vc_counter.sv
// ----------------------------------------------------------------------------
// tl_vc_counter
// Event counter with a build-time choice of wrap-around or saturation.
// Ports:
//   clk      in   single clock, posedge
//   reset    in   synchronous, active-high; clears the count
//   inc_i    in   count one event this cycle
//   cnt_o    out  current count (CNT_W bits)
// ----------------------------------------------------------------------------
module tl_vc_counter #(
    parameter int CNT_W    = 8,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // NOTE: every variable assigned in always_comb gets a default first, so
    // no path through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (inc_i) begin
            if (SATURATE && (&cnt_q)) begin
                cnt_d = cnt_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule : tl_vc_counter

// File: rtl/tl_vc_ingress_router.sv
// ----------------------------------------------------------------------------
// tl_vc_ingress_router
// Write side of the transaction-layer VC queues. Accepts one word per cycle,
// stages it, decodes the class field in the top two bits and pushes it into
// one of four VC FIFOs, honouring each FIFO's almost_full. Order is strictly
// preserved: a blocked word stalls the input, other VCs are never bypassed.
//
// Optional build macro: PARITY_CHECK_EN
//   defined   - words failing even parity are consumed, dropped, and counted
//               in err_cnt (saturating)
//   undefined - parity_in is ignored and err_cnt stays 0
//
// Ports:
//   clk            in   single clock, posedge
//   reset          in   synchronous, active-high
//   data_in        in   incoming word (class in [DATA_W-1:DATA_W-2])
//   valid_in       in   data_in valid
//   parity_in      in   even-parity bit over data_in
//   ready_out      out  word accepted when valid_in && ready_out
//   almost_full0-3 in   per-VC FIFO back-pressure
//   push0-3        out  per-VC push strobe, at most one high per cycle
//   data_out       out  word presented to all FIFOs (valid with a push)
//   state          out  one-hot link state RESET/INIT/IDLE/ACTIVE
//   cnt0-3         out  words pushed per VC, wrapping
//   err_cnt        out  parity-error words dropped, saturating
// ----------------------------------------------------------------------------
module tl_vc_ingress_router
    import tl_pkg::*;
#(
    parameter int DATA_W      = 10,
    parameter int INIT_CYCLES = 4,
    parameter int CNT_W       = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid_in,
    input  logic              parity_in,
    output logic              ready_out,
    input  logic              almost_full0,
    input  logic              almost_full1,
    input  logic              almost_full2,
    input  logic              almost_full3,
    output logic              push0,
    output logic              push1,
    output logic              push2,
    output logic              push3,
    output logic [DATA_W-1:0] data_out,
    output logic [3:0]        state,
    output logic [CNT_W-1:0]  cnt0,
    output logic [CNT_W-1:0]  cnt1,
    output logic [CNT_W-1:0]  cnt2,
    output logic [CNT_W-1:0]  cnt3,
    output logic [CNT_W-1:0]  err_cnt
);

    localparam int INIT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_CYCLES - 1);

    state_e              state_q, state_d;
    logic [INIT_W-1:0]   init_cnt_q, init_cnt_d;

    logic                stg_v_q, stg_v_d;
    logic [DATA_W-1:0]   stg_d_q, stg_d_d;
    logic [VC_W-1:0]     stg_dest;

    logic [NUM_VC-1:0]   af_vec;
    logic [NUM_VC-1:0]   push_vec;
    logic                fire;
    logic                accept;
    logic                parity_ok;
    logic                stage_load;
    logic                err_inc;

    assign af_vec   = {almost_full3, almost_full2, almost_full1, almost_full0};
    assign stg_dest = stg_d_q[DATA_W-1 -: VC_W];

    // Reset wins over a pending push: the staged word is discarded, not sent.
    assign fire      = stg_v_q && !af_vec[stg_dest] && !reset;
    assign ready_out = !reset && ((state_q == ST_IDLE) || (state_q == ST_ACTIVE))
                       && (!stg_v_q || fire);
    assign accept    = valid_in && ready_out;

`ifdef PARITY_CHECK_EN
    // Even parity: the word plus its parity bit must XOR to zero.
    assign parity_ok = ~(^{data_in, parity_in});
    assign err_inc   = accept && !parity_ok;
`else
    logic unused_parity;
    assign unused_parity = parity_in;
    assign parity_ok     = 1'b1;
    assign err_inc       = 1'b0;
`endif

    // A bad-parity word completes its handshake but never enters the stage.
    assign stage_load = accept && parity_ok;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        unique case (state_q)
            ST_RESET: begin
                state_d    = ST_INIT;
                init_cnt_d = '0;
            end
            ST_INIT: begin
                if (init_cnt_q == INIT_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    init_cnt_d = init_cnt_q + 1'b1;
                end
            end
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (!stg_v_q && !valid_in) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_RESET;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_RESET;
            init_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Stage register: a refill in the same cycle as a fire keeps the
    // stage full, giving one word per cycle throughput.
    // ------------------------------------------------------------------
    always_comb begin
        stg_v_d = stg_v_q;
        stg_d_d = stg_d_q;
        if (stage_load) begin
            stg_v_d = 1'b1;
            stg_d_d = data_in;
        end else if (fire) begin
            stg_v_d = 1'b0;
        end
    end

    // NOTE: the stage data is reset along with its valid bit so data_out and
    // the decoded destination never carry X or stale values after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            stg_v_q <= 1'b0;
            stg_d_q <= '0;
        end else begin
            stg_v_q <= stg_v_d;
            stg_d_q <= stg_d_d;
        end
    end

    // ------------------------------------------------------------------
    // Push decode and outputs
    // ------------------------------------------------------------------
    always_comb begin
        push_vec = '0;
        if (fire) begin
            push_vec[stg_dest] = 1'b1;
        end
    end

    assign push0    = push_vec[0];
    assign push1    = push_vec[1];
    assign push2    = push_vec[2];
    assign push3    = push_vec[3];
    assign data_out = fire ? stg_d_q : '0;
    assign state    = state_q;

    // ------------------------------------------------------------------
    // Counters: four wrapping per-VC counters plus a saturating error count
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] cnt_vec [NUM_VC];

    for (genvar g = 0; g < NUM_VC; g++) begin : g_vc_cnt
        tl_vc_counter #(
            .CNT_W    (CNT_W),
            .SATURATE (1'b0)
        ) u_cnt (
            .clk   (clk),
            .reset (reset),
            .inc_i (push_vec[g]),
            .cnt_o (cnt_vec[g])
        );
    end

    tl_vc_counter #(
        .CNT_W    (CNT_W),
        .SATURATE (1'b1)
    ) u_err_cnt (
        .clk   (clk),
        .reset (reset),
        .inc_i (err_inc),
        .cnt_o (err_cnt)
    );

    assign cnt0 = cnt_vec[0];
    assign cnt1 = cnt_vec[1];
    assign cnt2 = cnt_vec[2];
    assign cnt3 = cnt_vec[3];

endmodule : tl_vc_ingress_router

// File: tb/tb_tl_vc_ingress_router.sv
// ----------------------------------------------------------------------------
// tb_tl_vc_ingress_router
// Self-checking bench: directed stimulus pushes expected pushes into a
// scoreboard queue; a monitor on the falling edge pops and compares each push.
// ----------------------------------------------------------------------------
module tb_tl_vc_ingress_router;

    typedef struct packed {
        logic [1:0] vc;
        logic [9:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] data_in;
    logic       valid_in;
    logic       parity_in;
    logic       ready_out;
    logic       almost_full0, almost_full1, almost_full2, almost_full3;
    logic       push0, push1, push2, push3;
    logic [9:0] data_out;
    logic [3:0] state;
    logic [7:0] cnt0, cnt1, cnt2, cnt3, err_cnt;

    logic [3:0] push_v;
    assign push_v = {push3, push2, push1, push0};

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   push_seen = 0;

    always #5 clk = ~clk;

    tl_vc_ingress_router dut (
        .clk          (clk),
        .reset        (reset),
        .data_in      (data_in),
        .valid_in     (valid_in),
        .parity_in    (parity_in),
        .ready_out    (ready_out),
        .almost_full0 (almost_full0),
        .almost_full1 (almost_full1),
        .almost_full2 (almost_full2),
        .almost_full3 (almost_full3),
        .push0        (push0),
        .push1        (push1),
        .push2        (push2),
        .push3        (push3),
        .data_out     (data_out),
        .state        (state),
        .cnt0         (cnt0),
        .cnt1         (cnt1),
        .cnt2         (cnt2),
        .cnt3         (cnt3),
        .err_cnt      (err_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expect_push(input logic [1:0] vc, input logic [9:0] w);
        exp_t e;
        e.vc   = vc;
        e.data = w;
        exp_q.push_back(e);
    endtask

    // Scoreboard monitor: every cycle with a push must match the queue head.
    always @(negedge clk) begin
        if (push_v != 4'b0000) begin
            push_seen++;
            if (exp_q.size() == 0) begin
                check("unexpected_push", {28'd0, push_v}, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("push_vc", {28'd0, push_v}, 32'd1 << mon_e.vc);
                check("push_data", {22'd0, data_out}, {22'd0, mon_e.data});
            end
        end
    end

    // Send one word and wait (bounded) for its handshake.
    task automatic send(input logic [9:0] w, input logic p, input bit exp_push);
        int n;
        @(posedge clk); #1;
        valid_in  = 1'b1;
        data_in   = w;
        parity_in = p;
        if (exp_push) expect_push(w[9:8], w);
        n = 0;
        @(negedge clk);
        while (!ready_out && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!ready_out) check("send_accept", {31'd0, ready_out}, 32'd1);
        @(posedge clk); #1;
        valid_in = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (state != 4'b0100 && n < 30) begin
            @(negedge clk);
            n++;
        end
        check(name, {28'd0, state}, 32'h4);
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic [9:0] w4 [4];
        logic [9:0] w6 [8];
        logic       bad6 [8];
        int         stalls, p1, base;
        logic [9:0] w;

        reset = 1'b1; valid_in = 1'b0; data_in = '0; parity_in = 1'b0;
        almost_full0 = 1'b0; almost_full1 = 1'b0; almost_full2 = 1'b0; almost_full3 = 1'b0;

        // ---- 1: reset and INIT sequence ----
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("t1_state_reset", {28'd0, state}, 32'h1);
        check("t1_ready_reset", {31'd0, ready_out}, 32'd0);
        check("t1_data_reset", {22'd0, data_out}, 32'd0);
        check("t1_cnt_reset", {cnt0, cnt1, cnt2, cnt3}, 32'd0);
        check("t1_err_reset", {24'd0, err_cnt}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t1_state_init", {28'd0, state}, 32'h2);
        end
        @(negedge clk);
        check("t1_state_idle", {28'd0, state}, 32'h4);
        check("t1_ready_idle", {31'd0, ready_out}, 32'd1);

        // ---- 2: one word per class, push at N+1 ----
        w4[0] = 10'h005; w4[1] = 10'h1A1; w4[2] = 10'h2B2; w4[3] = 10'h3C3;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            valid_in = 1'b1; data_in = w4[i]; parity_in = ^w4[i];
            expect_push(2'(i), w4[i]);
            @(negedge clk);
            check("t2_ready", {31'd0, ready_out}, 32'd1);
            if (i == 0) begin
                check("t2_no_push_at_accept", {28'd0, push_v}, 32'd0);
                check("t2_state_idle", {28'd0, state}, 32'h4);
            end else begin
                check("t2_push_latency", {28'd0, push_v}, 32'd1 << (i - 1));
                check("t2_state_active", {28'd0, state}, 32'h8);
            end
        end
        @(posedge clk); #1;
        valid_in = 1'b0;
        @(negedge clk);
        check("t2_push3", {28'd0, push_v}, 32'h8);
        repeat (3) @(negedge clk);
        check("t2_back_to_idle", {28'd0, state}, 32'h4);
        check("t2_cnts", {cnt0, cnt1, cnt2, cnt3}, 32'h01010101);

        // ---- 3: blocked class 2, class 0 not bypassed ----
        @(posedge clk); #1;
        almost_full2 = 1'b1;
        valid_in = 1'b1; data_in = 10'h23C; parity_in = ^data_in;
        expect_push(2'd2, 10'h23C);
        @(negedge clk);
        check("t3_accept_c2", {31'd0, ready_out}, 32'd1);
        @(posedge clk); #1;
        data_in = 10'h099; parity_in = ^data_in;
        expect_push(2'd0, 10'h099);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t3_ready_blocked", {31'd0, ready_out}, 32'd0);
            check("t3_no_push_blocked", {28'd0, push_v}, 32'd0);
        end
        @(posedge clk); #1;
        almost_full2 = 1'b0;
        @(negedge clk);
        check("t3_push2_release", {28'd0, push_v}, 32'h4);
        check("t3_ready_on_fire", {31'd0, ready_out}, 32'd1);
        @(posedge clk); #1;
        valid_in = 1'b0;
        @(negedge clk);
        check("t3_push0_after", {28'd0, push_v}, 32'h1);
        wait_idle("t3_idle");

        // ---- 4: 256 back-to-back class-1 words, cnt1 wrap ----
        pulse_reset();
        wait_idle("t4_idle_after_reset");
        @(posedge clk); #1;
        almost_full0 = 1'b1; almost_full2 = 1'b1; almost_full3 = 1'b1;
        stalls = 0; p1 = 0;
        for (int i = 0; i < 256; i++) begin
            if (i != 0) begin
                @(posedge clk); #1;
            end
            w = {2'd1, 8'(i)};
            valid_in = 1'b1; data_in = w; parity_in = ^w;
            expect_push(2'd1, w);
            @(negedge clk);
            if (!ready_out) stalls++;
            if (push1) p1++;
            if (i == 128) check("t4_cnt1_mid", {24'd0, cnt1}, 32'd127);
        end
        @(posedge clk); #1;
        valid_in = 1'b0;
        @(negedge clk);
        if (push1) p1++;
        check("t4_cnt1_ff", {24'd0, cnt1}, 32'hFF);
        @(negedge clk);
        check("t4_stalls", stalls, 32'd0);
        check("t4_push1_cycles", p1, 32'd256);
        check("t4_cnt1_wrap", {24'd0, cnt1}, 32'h00);
        check("t4_other_cnts", {cnt0, cnt2, cnt3}, 32'd0);
        @(posedge clk); #1;
        almost_full0 = 1'b0; almost_full2 = 1'b0; almost_full3 = 1'b0;
        wait_idle("t4_idle");

        // ---- 5: reset with a blocked word in the stage ----
        send(10'h042, ^10'h042, 1'b1);
        repeat (2) @(negedge clk);
        check("t5_cnt0_pre", {24'd0, cnt0}, 32'd1);
        @(posedge clk); #1;
        almost_full3 = 1'b1;
        valid_in = 1'b1; data_in = 10'h377; parity_in = ^data_in;
        @(negedge clk);
        check("t5_accept_c3", {31'd0, ready_out}, 32'd1);
        @(posedge clk); #1;
        valid_in = 1'b0;
        @(negedge clk);
        check("t5_blocked", {28'd0, push_v}, 32'd0);
        base = push_seen;
        @(posedge clk); #1;
        reset = 1'b1;
        almost_full3 = 1'b0;
        @(negedge clk);
        check("t5_no_push_in_reset", {28'd0, push_v}, 32'd0);
        @(negedge clk);
        check("t5_state_reset", {28'd0, state}, 32'h1);
        check("t5_cnts_cleared", {cnt0, cnt1, cnt2, cnt3}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        wait_idle("t5_idle");
        repeat (2) @(negedge clk);
        check("t5_word_discarded", push_seen - base, 32'd0);

        // ---- 6: parity handling ----
        w6[0] = 10'h011; bad6[0] = 1'b0;
        w6[1] = 10'h122; bad6[1] = 1'b1;
        w6[2] = 10'h233; bad6[2] = 1'b0;
        w6[3] = 10'h344; bad6[3] = 1'b0;
        w6[4] = 10'h055; bad6[4] = 1'b1;
        w6[5] = 10'h166; bad6[5] = 1'b0;
        w6[6] = 10'h277; bad6[6] = 1'b1;
        w6[7] = 10'h388; bad6[7] = 1'b0;
        base = push_seen;
        for (int i = 0; i < 8; i++) begin
`ifdef PARITY_CHECK_EN
            send(w6[i], (^w6[i]) ^ bad6[i], !bad6[i]);
`else
            send(w6[i], (^w6[i]) ^ bad6[i], 1'b1);
`endif
        end
        repeat (4) @(negedge clk);
`ifdef PARITY_CHECK_EN
        check("t6_pushes", push_seen - base, 32'd5);
        check("t6_err_cnt", {24'd0, err_cnt}, 32'd3);
`else
        check("t6_pushes", push_seen - base, 32'd8);
        check("t6_err_cnt", {24'd0, err_cnt}, 32'd0);
`endif
        check("t6_state_idle", {28'd0, state}, 32'h4);
        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_tl_vc_ingress_router
